dbus_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the single CPU data-bus interface unit (DBIU) port among `NUM_M` bus masters, such as CPU cores and a debug/DMA agent. Each master drives the same req/adr/dat/we/sel request bundle and receives dat/ack. The arbiter grants one master at a time, forwards the granted bundle to the DBIU, and routes the DBIU acknowledge back to that master only. It sits between the masters and the DBIU-side adapter.

---
 rtl/param_pkg.sv | 6 +
 rtl/dbus_rr_arbiter_if.sv | 38 +++
 rtl/dbus_rr_arbiter.sv | 108 ++++++++++
 tb/tb_dbus_rr_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_pkg.sv
// Shared data-bus geometry used by the DBIU path and everything in front of it.
package param_pkg;
    localparam int DBUS_AW   = 32;
    localparam int DBUS_DW   = 32;
    localparam int DBUS_ISEL = 4;
endpackage

// File: rtl/dbus_rr_arbiter_if.sv
// Bundle of master-side and DBIU-side data-bus signals around the round-robin arbiter.
// Valid/ready: a master holds req and its adr/dat/we/sel stable until it sees its ack bit; ack is a one-cycle pulse.
interface dbus_rr_arbiter_if #(
    parameter int NUM_M = 2
);
    logic [NUM_M-1:0]                          req_m2arb;
    logic [NUM_M-1:0][param_pkg::DBUS_AW-1:0]  adr_m2arb;
    logic [NUM_M-1:0][param_pkg::DBUS_DW-1:0]  dat_m2arb;
    logic [NUM_M-1:0]                          we_m2arb;
    logic [NUM_M-1:0][param_pkg::DBUS_ISEL-1:0] sel_m2arb;
    logic [param_pkg::DBUS_DW-1:0]             dat_arb2m;
    logic [NUM_M-1:0]                          ack_arb2m;
    logic [NUM_M-1:0]                          gnt_arb2m;

    logic                                      req_m2dbiu;
    logic [param_pkg::DBUS_AW-1:0]             adr_m2dbiu;
    logic [param_pkg::DBUS_DW-1:0]             dat_m2dbiu;
    logic                                      we_m2dbiu;
    logic [param_pkg::DBUS_ISEL-1:0]           sel_m2dbiu;
    logic [param_pkg::DBUS_DW-1:0]             dat_dbiu2m;
    logic                                      ack_dbiu2m;

    // Environment view: the masters plus the DBIU adapter.
    modport master (
        output req_m2arb, adr_m2arb, dat_m2arb, we_m2arb, sel_m2arb,
        output dat_dbiu2m, ack_dbiu2m,
        input  dat_arb2m, ack_arb2m, gnt_arb2m,
        input  req_m2dbiu, adr_m2dbiu, dat_m2dbiu, we_m2dbiu, sel_m2dbiu
    );

    // Arbiter view.
    modport slave (
        input  req_m2arb, adr_m2arb, dat_m2arb, we_m2arb, sel_m2arb,
        input  dat_dbiu2m, ack_dbiu2m,
        output dat_arb2m, ack_arb2m, gnt_arb2m,
        output req_m2dbiu, adr_m2dbiu, dat_m2dbiu, we_m2dbiu, sel_m2dbiu
    );
endinterface

// File: rtl/dbus_rr_arbiter.sv
// Round-robin arbiter sharing the single DBIU data-bus port among NUM_M masters.
// One grant at a time; an IDLE cycle always separates consecutive grants.
module dbus_rr_arbiter #(
    parameter int NUM_M = 2
) (
    input  logic             clk,
    input  logic             rst,
    dbus_rr_arbiter_if.slave bus,
    output logic [0:0]       state_dbg
);
    localparam int IDX_W = $clog2(NUM_M);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_M - 1);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] gnt_idx_nxt;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] last_idx_nxt;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             pick_vld;
    logic             busy;
    logic             gnt_req;
    logic [NUM_M-1:0] gnt_oh;
    int               cand;

    assign busy    = (state == ST_BUSY);
    assign gnt_req = bus.req_m2arb[gnt_idx];
    assign gnt_oh  = NUM_M'(1) << gnt_idx;

    // First requester strictly after last_idx, wrapping modulo NUM_M.
    always_comb begin
        pick_idx = last_idx;
        pick_vld = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_M; i++) begin
            cand = int'(last_idx) + i;
            if (cand >= NUM_M) begin
                cand = cand - NUM_M;
            end
            cand_idx = IDX_W'(cand);
            if (!pick_vld && bus.req_m2arb[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        gnt_idx_nxt  = gnt_idx;
        last_idx_nxt = last_idx;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_idx_nxt = pick_idx;
                    state_nxt   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Completion and abort both retire the grant and rotate priority.
                if (bus.ack_dbiu2m || !gnt_req) begin
                    last_idx_nxt = gnt_idx;
                    state_nxt    = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt_idx  <= '0;
            last_idx <= LAST_RST;
        end else begin
            state    <= state_nxt;
            gnt_idx  <= gnt_idx_nxt;
            last_idx <= last_idx_nxt;
        end
    end

    // Forwarded bundle is forced to zero outside BUSY so nothing leaks to the DBIU.
    assign bus.req_m2dbiu = busy & gnt_req;
    assign bus.adr_m2dbiu = busy ? bus.adr_m2arb[gnt_idx] : '0;
    assign bus.dat_m2dbiu = busy ? bus.dat_m2arb[gnt_idx] : '0;
    assign bus.we_m2dbiu  = busy & bus.we_m2arb[gnt_idx];
    assign bus.sel_m2dbiu = busy ? bus.sel_m2arb[gnt_idx] : '0;

    assign bus.dat_arb2m  = bus.dat_dbiu2m;
    assign bus.ack_arb2m  = (busy && bus.ack_dbiu2m) ? gnt_oh : '0;
    assign bus.gnt_arb2m  = busy ? gnt_oh : '0;

    assign state_dbg      = state;

    ap_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.gnt_arb2m));
    ap_ack_in_gnt: assert property (@(posedge clk) disable iff (rst)
        ((bus.ack_arb2m & ~bus.gnt_arb2m) == '0));
endmodule

// File: tb/tb_dbus_rr_arbiter.sv
// Bench for dbus_rr_arbiter: directed scenarios, then random masters/DBIU against a
// transaction-level round-robin reference model.
module tb_dbus_rr_arbiter;
    import param_pkg::*;

    localparam int NM = 4;
    localparam int AW = DBUS_AW;
    localparam int DW = DBUS_DW;
    localparam int SW = DBUS_ISEL;
    localparam int BW = AW + DW + 1 + SW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:0] state_dbg;

    dbus_rr_arbiter_if #(.NUM_M(NM)) bus ();

    dbus_rr_arbiter #(.NUM_M(NM)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NM-1:0] exp_q[$];
    logic [BW-1:0] txn[NM];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.req_m2arb  = '0;
        bus.adr_m2arb  = '0;
        bus.dat_m2arb  = '0;
        bus.we_m2arb   = '0;
        bus.sel_m2arb  = '0;
        bus.ack_dbiu2m = 1'b0;
        bus.dat_dbiu2m = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_master(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic w, input logic [SW-1:0] s);
        bus.adr_m2arb[m] = a;
        bus.dat_m2arb[m] = d;
        bus.we_m2arb[m]  = w;
        bus.sel_m2arb[m] = s;
        bus.req_m2arb[m] = 1'b1;
        txn[m]           = {a, d, w, s};
    endtask

    task automatic raise_random(input int m);
        set_master(m, AW'($urandom()), DW'($urandom()), 1'($urandom_range(0, 1)),
                   SW'($urandom_range(0, (1 << SW) - 1)));
    endtask

    function automatic logic [BW-1:0] fwd();
        return {bus.adr_m2dbiu, bus.dat_m2dbiu, bus.we_m2dbiu, bus.sel_m2dbiu};
    endfunction

    // Reference rule: first requester after 'last', wrapping; -1 when nobody requests.
    function automatic int rr_pick(input int last, input logic [NM-1:0] reqs);
        for (int k = 1; k <= NM; k++) begin
            if (reqs[(last + k) % NM]) return (last + k) % NM;
        end
        return -1;
    endfunction

    // ---------------- random-phase state ----------------
    int            prev_owner;
    int            exp_owner;
    int            ref_last;
    int            n_grants;
    int            wait_cnt[NM];
    logic [NM-1:0] prev_req;
    logic          prev_ack;
    logic [NM-1:0] finished;
    logic [NM-1:0] drop;
    logic [NM-1:0] exp_gnt;

    initial begin
        // ---------- reset state ----------
        idle_inputs();
        bus.dat_dbiu2m = 32'h1234_5678;
        #3;
        check("rst_req", bus.req_m2dbiu, 1'b0);
        check("rst_gnt", bus.gnt_arb2m, 4'b0000);
        check("rst_ack", bus.ack_arb2m, 4'b0000);
        check("rst_state", state_dbg, 1'b0);
        check("rst_fwd", fwd(), '0);
        check("rst_dat", bus.dat_arb2m, 32'h1234_5678);

        // ---------- single master ----------
        do_reset();
        step();
        set_master(0, 32'h100, 32'hDEAD_BEEF, 1'b1, 4'hF);
        sample();
        check("t1_req_idle", bus.req_m2dbiu, 1'b0);
        step();
        sample();
        check("t1_req", bus.req_m2dbiu, 1'b1);
        check("t1_gnt", bus.gnt_arb2m, 4'b0001);
        check("t1_fwd", fwd(), {32'h100, 32'hDEAD_BEEF, 1'b1, 4'hF});
        check("t1_ack_early", bus.ack_arb2m, 4'b0000);
        repeat (2) begin
            step();
            sample();
            check("t1_ack_wait", bus.ack_arb2m, 4'b0000);
        end
        step();
        bus.dat_dbiu2m = 32'hCAFE_F00D;
        bus.ack_dbiu2m = 1'b1;
        sample();
        check("t1_ack", bus.ack_arb2m, 4'b0001);
        check("t1_rdata", bus.dat_arb2m, 32'hCAFE_F00D);
        step();
        bus.ack_dbiu2m   = 1'b0;
        bus.req_m2arb[0] = 1'b0;
        sample();
        check("t1_ack_clr", bus.ack_arb2m, 4'b0000);
        check("t1_gnt_clr", bus.gnt_arb2m, 4'b0000);
        check("t1_state_idle", state_dbg, 1'b0);

        // ---------- contention ----------
        do_reset();
        step();
        set_master(0, 32'h200, 32'h1111_1111, 1'b1, 4'h3);
        set_master(1, 32'h300, 32'h2222_2222, 1'b0, 4'hC);
        sample();
        check("t2_idle", bus.gnt_arb2m, 4'b0000);
        step();
        bus.ack_dbiu2m = 1'b1;
        sample();
        check("t2_gnt0", bus.gnt_arb2m, 4'b0001);
        check("t2_ack0", bus.ack_arb2m, 4'b0001);
        check("t2_fwd0", fwd(), {32'h200, 32'h1111_1111, 1'b1, 4'h3});
        step();
        bus.ack_dbiu2m   = 1'b0;
        bus.req_m2arb[0] = 1'b0;
        sample();
        check("t2_gap_gnt", bus.gnt_arb2m, 4'b0000);
        check("t2_gap_req", bus.req_m2dbiu, 1'b0);
        step();
        bus.ack_dbiu2m = 1'b1;
        sample();
        check("t2_gnt1", bus.gnt_arb2m, 4'b0010);
        check("t2_ack1", bus.ack_arb2m, 4'b0010);
        check("t2_fwd1", fwd(), {32'h300, 32'h2222_2222, 1'b0, 4'hC});
        step();
        bus.ack_dbiu2m   = 1'b0;
        bus.req_m2arb[1] = 1'b0;
        sample();
        check("t2_end_gnt", bus.gnt_arb2m, 4'b0000);

        // ---------- rotation, DBIU acks in the granted cycle ----------
        do_reset();
        for (int m = 0; m < NM; m++) begin
            set_master(m, AW'(32'h1000 + m), DW'(m), 1'b0, 4'h1);
        end
        bus.req_m2arb = '0;
        exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        drop  = '0;
        for (int c = 0; c < 12; c++) begin
            step();
            bus.req_m2arb = ~drop;
            #1;
            bus.ack_dbiu2m = bus.req_m2dbiu;
            sample();
            if (c % 2 == 1) begin
                exp_gnt = exp_q.pop_front();
                check("t3_gnt", bus.gnt_arb2m, exp_gnt);
                check("t3_ack", bus.ack_arb2m, exp_gnt);
                drop = exp_gnt;
            end else begin
                check("t3_idle", bus.gnt_arb2m, 4'b0000);
                drop = '0;
            end
        end
        check("t3_q_empty", exp_q.size(), 0);
        step();
        bus.req_m2arb  = '0;
        bus.ack_dbiu2m = 1'b0;
        sample();

        // ---------- abort ----------
        do_reset();
        step();
        set_master(0, 32'h40, 32'hA0A0_A0A0, 1'b1, 4'hF);
        sample();
        step();
        bus.ack_dbiu2m = 1'b1;
        sample();
        check("t4_gnt0", bus.gnt_arb2m, 4'b0001);
        step();
        bus.ack_dbiu2m   = 1'b0;
        bus.req_m2arb[0] = 1'b0;
        sample();
        step();
        set_master(1, 32'h44, 32'hB1B1_B1B1, 1'b0, 4'h1);
        sample();
        step();
        set_master(0, 32'h48, 32'hC0C0_C0C0, 1'b1, 4'h6);
        sample();
        check("t4_gnt1", bus.gnt_arb2m, 4'b0010);
        check("t4_req1", bus.req_m2dbiu, 1'b1);
        step();
        bus.req_m2arb[1] = 1'b0;
        sample();
        check("t4_abort_req", bus.req_m2dbiu, 1'b0);
        check("t4_abort_ack", bus.ack_arb2m, 4'b0000);
        step();
        sample();
        check("t4_idle_state", state_dbg, 1'b0);
        check("t4_idle_gnt", bus.gnt_arb2m, 4'b0000);
        step();
        sample();
        check("t4_next_gnt", bus.gnt_arb2m, 4'b0001);
        check("t4_next_fwd", fwd(), {32'h48, 32'hC0C0_C0C0, 1'b1, 4'h6});
        step();
        bus.ack_dbiu2m = 1'b1;
        sample();
        check("t4_next_ack", bus.ack_arb2m, 4'b0001);
        step();
        bus.ack_dbiu2m   = 1'b0;
        bus.req_m2arb[0] = 1'b0;
        sample();

        // ---------- spurious ack in IDLE ----------
        step();
        bus.ack_dbiu2m = 1'b1;
        bus.dat_dbiu2m = 32'h5555_AAAA;
        sample();
        check("t5_ack", bus.ack_arb2m, 4'b0000);
        check("t5_state", state_dbg, 1'b0);
        step();
        bus.ack_dbiu2m = 1'b0;
        sample();
        check("t5_state_after", state_dbg, 1'b0);
        check("t5_gnt_after", bus.gnt_arb2m, 4'b0000);

        // ---------- reset while master 2 is granted ----------
        do_reset();
        step();
        set_master(2, 32'h80, 32'h2222_0002, 1'b1, 4'h8);
        sample();
        step();
        sample();
        check("t6_gnt2", bus.gnt_arb2m, 4'b0100);
        step();
        set_master(0, 32'h84, 32'h0000_0000, 1'b0, 4'h2);
        bus.ack_dbiu2m = 1'b1;
        rst = 1'b1;
        #1;
        check("t6_rst_req", bus.req_m2dbiu, 1'b0);
        check("t6_rst_gnt", bus.gnt_arb2m, 4'b0000);
        check("t6_rst_ack", bus.ack_arb2m, 4'b0000);
        check("t6_rst_state", state_dbg, 1'b0);
        sample();
        bus.ack_dbiu2m = 1'b0;
        rst = 1'b0;
        step();
        sample();
        check("t6_prio0", bus.gnt_arb2m, 4'b0001);
        step();
        bus.ack_dbiu2m = 1'b1;
        sample();
        check("t6_ack0", bus.ack_arb2m, 4'b0001);
        step();
        bus.ack_dbiu2m   = 1'b0;
        bus.req_m2arb[0] = 1'b0;
        sample();
        step();
        sample();
        check("t6_then2", bus.gnt_arb2m, 4'b0100);
        step();
        bus.ack_dbiu2m = 1'b1;
        sample();
        check("t6_ack2", bus.ack_arb2m, 4'b0100);
        step();
        bus.ack_dbiu2m   = 1'b0;
        bus.req_m2arb[2] = 1'b0;
        sample();

        // ---------- random masters and DBIU vs reference model ----------
        do_reset();
        prev_owner = -1;
        ref_last   = NM - 1;
        prev_req   = '0;
        prev_ack   = 1'b0;
        finished   = '0;
        n_grants   = 0;
        for (int m = 0; m < NM; m++) wait_cnt[m] = 0;
        for (int c = 0; c < 600; c++) begin
            step();
            if (prev_owner < 0) begin
                exp_owner = rr_pick(ref_last, prev_req);
            end else if (prev_ack || !prev_req[prev_owner]) begin
                ref_last  = prev_owner;
                exp_owner = -1;
            end else begin
                exp_owner = prev_owner;
            end
            if (prev_owner < 0 && exp_owner >= 0) begin
                n_grants++;
                check("rnd_fair", wait_cnt[exp_owner] <= NM - 1, 1'b1);
                wait_cnt[exp_owner] = 0;
                for (int m = 0; m < NM; m++) begin
                    if (m != exp_owner && prev_req[m]) wait_cnt[m]++;
                end
            end

            for (int m = 0; m < NM; m++) begin
                if (finished[m]) begin
                    bus.req_m2arb[m] = 1'b0;
                    finished[m]      = 1'b0;
                end else if (!bus.req_m2arb[m]) begin
                    if ($urandom_range(0, 3) == 0) raise_random(m);
                end else if (m == exp_owner && $urandom_range(0, 15) == 0) begin
                    bus.req_m2arb[m] = 1'b0;
                end
            end

            bus.dat_dbiu2m = DW'($urandom());
            if (exp_owner >= 0) begin
                bus.ack_dbiu2m = bus.req_m2arb[exp_owner] && ($urandom_range(0, 2) == 0);
            end else begin
                bus.ack_dbiu2m = ($urandom_range(0, 7) == 0);
            end
            sample();

            exp_gnt = (exp_owner >= 0) ? (NM'(1) << exp_owner) : '0;
            check("rnd_gnt", bus.gnt_arb2m, exp_gnt);
            check("rnd_dat", bus.dat_arb2m, bus.dat_dbiu2m);
            if (exp_owner >= 0) begin
                check("rnd_req", bus.req_m2dbiu, bus.req_m2arb[exp_owner]);
                check("rnd_ack", bus.ack_arb2m, bus.ack_dbiu2m ? exp_gnt : '0);
                if (bus.req_m2arb[exp_owner]) check("rnd_fwd", fwd(), txn[exp_owner]);
                if (bus.ack_dbiu2m) finished[exp_owner] = 1'b1;
            end else begin
                check("rnd_req_idle", bus.req_m2dbiu, 1'b0);
                check("rnd_ack_idle", bus.ack_arb2m, '0);
            end
            prev_owner = exp_owner;
            prev_req   = bus.req_m2arb;
            prev_ack   = bus.ack_dbiu2m;
        end
        check("rnd_activity", n_grants > 20, 1'b1);

        // ---------- report ----------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
